// File: rtl/log_norm_pipe.sv
// Mitchell log-domain normalizer: leading-one code check plus fraction extraction.
// Two-stage valid/ready pipeline with full backpressure, 1 beat/cycle.
module log_norm_pipe #(
    parameter int DATA_W = 12,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [3:0]        in_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_exp,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_zero,
    output logic              out_err
);

    localparam int LW     = DATA_W - 1;
    localparam int WIDE_W = LW + 16;

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [3:0]        s1_p_q;
    logic              s1_zero_q;
    logic              s1_err_q;

    logic              out_valid_q;
    logic [3:0]        out_exp_q;
    logic [FRAC_W-1:0] out_frac_q;
    logic              out_zero_q;
    logic              out_err_q;

    logic              s1_adv;
    logic              s2_adv;

    logic [3:0]        dec_p;
    logic [DATA_W-1:0] low_mask;
    logic [DATA_W-1:0] p_sel;
    logic              dec_hit;
    logic              dec_zero;
    logic              dec_err;

    logic [LW-1:0]     norm_lo;
    logic [WIDE_W-1:0] wide;
    logic [3:0]        exp_d;
    logic [FRAC_W-1:0] frac_d;
    logic              unused_wide;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // Code 12 is the encoder's alias for bit 11; 13..15 are illegal.
    always_comb begin
        dec_p = 4'd0;
        if (in_pos <= 4'd11) begin
            dec_p = in_pos;
        end else if (in_pos == 4'd12) begin
            dec_p = 4'd11;
        end
        low_mask = {DATA_W{1'b1}} >> (4'd11 - dec_p);
        p_sel    = {{(DATA_W-1){1'b0}}, 1'b1} << dec_p;
        dec_hit  = |(in_data & p_sel);
        dec_zero = ~|in_data;
        dec_err  = !dec_zero
                && ((in_pos > 4'd12) || !dec_hit
                    || (|(in_data & ~low_mask)));
    end

    always_comb begin
        norm_lo     = LW'(s1_data_q << (4'd11 - s1_p_q));
        wide        = {norm_lo, 16'b0};
        frac_d      = s1_zero_q ? '0 : wide[WIDE_W-1 -: FRAC_W];
        exp_d       = s1_zero_q ? 4'd0 : s1_p_q;
        unused_wide = ^wide[WIDE_W-FRAC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_exp_q   <= '0;
            out_frac_q  <= '0;
            out_zero_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_exp_q  <= exp_d;
                    out_frac_q <= frac_d;
                    out_zero_q <= s1_zero_q;
                    out_err_q  <= s1_err_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_data_q <= in_data;
            s1_p_q    <= dec_p;
            s1_zero_q <= dec_zero;
            s1_err_q  <= dec_err;
        end
    end

    assign out_valid = out_valid_q;
    assign out_exp   = out_exp_q;
    assign out_frac  = out_frac_q;
    assign out_zero  = out_zero_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_log_norm_pipe.sv
// Bench for log_norm_pipe: vector table, stall/reset sequences,
// and random traffic against a scoreboard of expected beats.
module tb_log_norm_pipe;

    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [11:0]   in_data;
    logic [3:0]    in_pos;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_exp;
    logic [FW-1:0] out_frac;
    logic          out_zero;
    logic          out_err;

    always #5 clk = ~clk;

    log_norm_pipe #(.DATA_W(12), .FRAC_W(FW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_pos    (in_pos),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_exp   (out_exp),
        .out_frac  (out_frac),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    typedef struct packed {
        logic [3:0] exp;
        logic [7:0] frac;
        logic       zero;
        logic       err;
    } res_t;

    typedef struct {
        logic [11:0] d;
        logic [3:0]  c;
        res_t        e;
    } vec_t;

    res_t exp_q[$];
    res_t cur_exp;
    res_t prev_res;
    logic prev_stall;
    logic fired;
    int   n_pass;
    int   n_total;
    int   n_out;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Reference: leading-one index from the code, fraction as the bits
    // below bit p scaled into FW bits.
    function automatic res_t model(input logic [11:0] d, input logic [3:0] c);
        res_t r;
        int   p;
        int   hi;
        int   lowv;
        r = '0;
        if (d == 12'h000) begin
            r.zero = 1'b1;
            return r;
        end
        p = (c <= 11) ? int'(c) : ((c == 12) ? 11 : 0);
        hi = -1;
        for (int i = 0; i < 12; i++) if (d[i]) hi = i;
        r.err  = (c > 12) || (hi != p);
        r.exp  = 4'(p);
        lowv   = int'(d) & ((1 << p) - 1);
        r.frac = 8'((lowv << FW) >> p);
        return r;
    endfunction

    task automatic new_beat();
        int          r;
        int          p;
        logic [11:0] d;
        logic [3:0]  c;
        r = $urandom_range(0, 9);
        if (r == 0) begin
            d = 12'h000;
            c = 4'($urandom);
        end else if (r <= 6) begin
            p = $urandom_range(0, 11);
            d = 12'((1 << p) | ($urandom & ((1 << p) - 1)));
            c = (p == 11 && $urandom_range(0, 1) == 1) ? 4'd12 : 4'(p);
        end else begin
            d = 12'($urandom);
            c = 4'($urandom);
        end
        in_data = d;
        in_pos  = c;
        cur_exp = model(d, c);
    endtask

    task automatic cycle();
        res_t act;
        res_t e;
        @(negedge clk);
        act = {out_exp, out_frac, out_zero, out_err};
        fired = 1'b0;
        if (!rst) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_payload", 32'(act), 32'(prev_res));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_beat: got %h expected none", act);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 32'(act), 32'(e));
                    n_out++;
                end
            end
            fired = in_valid && in_ready;
            if (fired) exp_q.push_back(cur_exp);
            prev_stall = out_valid && !out_ready;
            prev_res   = act;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[13];

    initial begin
        int lat;
        int acc;
        int cyc;
        int base;

        n_pass = 0; n_total = 0; n_out = 0;
        prev_stall = 1'b0; fired = 1'b0; cur_exp = '0; prev_res = '0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_pos = '0;

        vecs[0]  = '{12'h0A0, 4'd7,  '{4'd7,  8'h40, 1'b0, 1'b0}};
        vecs[1]  = '{12'h800, 4'd12, '{4'd11, 8'h00, 1'b0, 1'b0}};
        vecs[2]  = '{12'h800, 4'd11, '{4'd11, 8'h00, 1'b0, 1'b0}};
        vecs[3]  = '{12'h000, 4'd0,  '{4'd0,  8'h00, 1'b1, 1'b0}};
        vecs[4]  = '{12'h010, 4'd3,  '{4'd3,  8'h00, 1'b0, 1'b1}};
        vecs[5]  = '{12'h001, 4'd14, '{4'd0,  8'h00, 1'b0, 1'b1}};
        vecs[6]  = '{12'h000, 4'd15, '{4'd0,  8'h00, 1'b1, 1'b0}};
        vecs[7]  = '{12'hFFF, 4'd11, '{4'd11, 8'hFF, 1'b0, 1'b0}};
        vecs[8]  = '{12'h001, 4'd0,  '{4'd0,  8'h00, 1'b0, 1'b0}};
        vecs[9]  = '{12'h003, 4'd1,  '{4'd1,  8'h80, 1'b0, 1'b0}};
        vecs[10] = '{12'h0A0, 4'd12, '{4'd11, 8'h14, 1'b0, 1'b1}};
        vecs[11] = '{12'h400, 4'd10, '{4'd10, 8'h00, 1'b0, 1'b0}};
        vecs[12] = '{12'h555, 4'd10, '{4'd10, 8'h55, 1'b0, 1'b0}};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_exp", 32'(out_exp), 32'd0);
        chk("rst_frac", 32'(out_frac), 32'd0);
        chk("rst_zero", 32'(out_zero), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        @(posedge clk);
        #1;

        // Directed vectors, one beat at a time, unstalled.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_data  = vecs[i].d;
            in_pos   = vecs[i].c;
            cur_exp  = vecs[i].e;
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            lat = 0;
            while (exp_q.size() > 0 && lat < 10) begin
                cycle();
                lat++;
            end
            chk($sformatf("latency_v%0d", i), 32'(lat), 32'd2);
        end

        // Six beats against a 4-cycle stall.
        out_ready = 1'b0;
        acc  = 0;
        base = n_out;
        new_beat();
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (acc >= 2) chk("stall_in_ready", 32'(in_ready), 32'd0);
            cycle();
            if (fired) begin
                acc++;
                new_beat();
            end
        end
        chk("stall_accepts", 32'(acc), 32'd2);
        out_ready = 1'b1;
        cyc = 0;
        while ((acc < 6 || exp_q.size() > 0) && cyc < 50) begin
            if (acc >= 6) in_valid = 1'b0;
            cycle();
            if (fired) begin
                acc++;
                new_beat();
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk("stall_delivered", 32'(n_out - base), 32'd6);
        chk("stall_drain", 32'(exp_q.size()), 32'd0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        acc = 0;
        cyc = 0;
        new_beat();
        in_valid = 1'b1;
        while (acc < 2 && cyc < 10) begin
            cycle();
            if (fired) begin
                acc++;
                new_beat();
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk("rst_fill", 32'(acc), 32'd2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_q.delete();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_payload",
            32'({out_exp, out_frac, out_zero, out_err}), 32'd0);
        base = n_out;
        out_ready = 1'b1;
        repeat (6) cycle();
        chk("midrst_no_stale", 32'(n_out - base), 32'd0);

        // Random traffic.
        acc = 0;
        cyc = 0;
        base = n_out;
        while (acc < 10000 && cyc < 60000) begin
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = ($urandom_range(0, 9) < 7);
            new_beat();
            cycle();
            if (fired) acc++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 10) begin
            cycle();
            cyc++;
        end
        chk("rand_accepted", 32'(acc), 32'd10000);
        chk("rand_delivered", 32'(n_out - base), 32'd10000);
        chk("rand_drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
